hdr_stream_merge: RTL
=====================

# hdr_stream_merge

Parametrised HDR exposure-merge stage with full Avalon-ST handshaking. It joins two packetised pixel streams, a long exposure on sink 0 and a short exposure on sink 1. The streams are aligned at start-of-packet and blended per lane in a fixed 3-stage pipeline. Results are buffered in a credit-protected output FIFO so that downstream backpressure is honoured. It sits between the dual-exposure capture path and the video output path, and adds lane-count generality, packet realignment and error reporting.

## Interface
- LANES, 2, number of pixel lanes per beat (e.g. Y and CrCb).
- LANE_W, 8, bits per lane.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, ≥4.
- DATA_WIDTH, LANES*LANE_W, derived; not overridden.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- asi_snk_0_valid_i / asi_snk_1_valid_i  in  1  sink beat valid (0 = long, 1 = short exposure).
- asi_snk_0_ready_o / asi_snk_1_ready_o  out  1  sink ready.
- asi_snk_0_data_i / asi_snk_1_data_i  in  DATA_WIDTH  lane k at [k*LANE_W +: LANE_W].
- asi_snk_0_startofpacket_i / asi_snk_1_startofpacket_i  in  1  SOP.
- asi_snk_0_endofpacket_i / asi_snk_1_endofpacket_i  in  1  EOP.
- aso_src_valid_o  out  1  source valid.
- aso_src_ready_i  in  1  source ready.
- aso_src_data_o  out  DATA_WIDTH  merged lanes.
- aso_src_startofpacket_o / aso_src_endofpacket_o  out  1  packet markers.
- aso_src_error_o  out  1  beat terminates a misaligned packet.
- frame_cnt_o  out  16  good packets accepted; wraps.
- resync_cnt_o  out  8  misalignment events; saturates at 255.

## Operation
- **Pair accept:** a beat is taken from both sinks in the same cycle, or from neither. The only exception is drops in ALIGN.
- **Credit counter:** counts beats accepted but not yet popped from the FIFO. It is incremented on pair accept and decremented on source transfer (valid & ready). `space = credit < FIFO_DEPTH`.
- **State ALIGN** (reset state):
  - A sink whose head is valid and not SOP is dropped: its ready_o = 1.
  - A sink whose head is SOP is held.
  - When both heads are SOP and `space`, both ready_o = 1 and the pair is accepted.
  - If the pair also has EOP on both sinks (single-beat packet), stay in ALIGN. Otherwise go to RUN.
- **State RUN:**
  - `asi_snk_0_ready_o = space & asi_snk_1_valid_i` and `asi_snk_1_ready_o = space & asi_snk_0_valid_i`. Ready never depends on the sink's own valid.
  - Good pair, both EOP, no SOP: frame_cnt_o increments, go to ALIGN.
  - Good pair, neither EOP nor SOP: stay in RUN.
  - **Misaligned pair:** EOP on exactly one sink, or SOP on either. The beat is emitted with error = 1, eop = 1, sop = 0. resync_cnt_o increments (saturating). Go to ALIGN. The unfinished stream's remainder is then dropped in ALIGN.
- **Merge,** per lane, with L = sink 0 lane and S = sink 1 lane, unsigned: `out = (L*(2^LANE_W − L) + S*L) >> LANE_W`.
  - Products are 2*LANE_W bits; the sum fits in 2*LANE_W bits.
  - The result always fits in LANE_W bits; no saturation logic.
  - Dark L selects L; saturated L selects S.
- **Pipeline:**
  - Stage 1 registers L, S and markers.
  - Stage 2 registers the two products.
  - Stage 3 registers sum >> LANE_W.
  - The pipeline never stalls; credits guarantee a FIFO slot.
- **FIFO:** show-ahead; stores {error, eop, sop, data}. The source outputs present the FIFO head.

## Timing
- Reset values:
  - All ready_o = 0 and aso_src_valid_o = 0.
  - data, sop, eop, error = 0.
  - Counters = 0, credit = 0, FIFO empty, state ALIGN.
  - Pipeline valids cleared.
- **Reset mid-operation:** in-flight and buffered beats are discarded. No partial packet is emitted after reset release.
- **Latency:** a pair accepted at edge k appears as aso_src_valid_o = 1 after edge k+4, when the FIFO is empty and no backpressure is applied.
- **Throughput:** one pair per cycle while `space` holds and the source is ready.
- **FIFO_DEPTH full:** with aso_src_ready_i = 0, exactly FIFO_DEPTH pairs are accepted, then both ready_o = 0. This holds even with 3 beats in flight.
- **Credit update:** a simultaneous accept and pop leaves credit unchanged.
- **Source rule:** aso_src_valid_o holds, with data, sop, eop and error stable, until aso_src_ready_i = 1.
- **Counter timing:** frame_cnt_o and resync_cnt_o update on the accept edge.

## Test plan
- **Arithmetic:** lane pairs (L, S) are (0x00, 0xFF) → 0x00, (0x80, 0x40) → 0x60, (0xFF, 0x10) → 0x10, (0xFF, 0xFF) → 0xFF. Check all lanes independently with LANES = 2, then LANES = 3.
- **Aligned streaming:** two aligned 16-beat packets with continuous valid and ready → 32 output beats. Check SOP on beats 0/16, EOP on beats 15/31, error = 0, frame_cnt_o = 2, first valid 4 cycles after the first accept.
- **Offset start:** sink 0 starts with 5 tail beats, then a 4-beat packet; sink 1 starts with the packet directly → the 5 beats are dropped, one 4-beat output packet, resync_cnt_o = 0.
- **Misalignment:** sink 0 EOP at beat 3, sink 1 EOP at beat 5 → output beat 3 has eop = 1, error = 1; resync_cnt_o = 1; sink 1's beats 4–5 are dropped; the next aligned packet passes clean.
- **Backpressure:** aso_src_ready_i = 0 for 20 cycles with FIFO_DEPTH = 8 → exactly 8 pairs accepted. Releasing ready drains them in order with no loss or duplication. Random ready at 50% over 1000 beats matches the reference model.
- **Reset mid-packet:** assert rst during beat 6 of 10 → all outputs 0 immediately. After release, the next output beat is the SOP of the following packet, and the counters restart at 0.

Source files
------------

// File: rtl/hdr_stream_merge_if.sv
// One Avalon-ST link: valid/ready handshake plus packet markers and data.
// A beat transfers on a rising edge where valid & ready are both 1. The master holds
// valid, data and markers stable until that edge. Ready may be asserted ahead of valid.
interface hdr_stream_merge_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  startofpacket;
    logic                  endofpacket;
    logic                  error;

    // Sinks of the merge stage carry no error flag, so the slave side omits it.
    modport master (output valid, data, startofpacket, endofpacket, error, input ready);
    modport slave  (input  valid, data, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/hdr_stream_merge.sv
// HDR exposure merge: pairs long (sink 0) and short (sink 1) exposure beats, blends each
// lane in a 3-stage pipeline and buffers results in a credit-protected show-ahead FIFO.
module hdr_stream_merge #(
    parameter  int LANES      = 2,
    parameter  int LANE_W     = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int DATA_WIDTH = LANES * LANE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    hdr_stream_merge_if.slave         asi_snk_0,
    hdr_stream_merge_if.slave         asi_snk_1,
    hdr_stream_merge_if.master        aso_src,
    output logic [15:0]               frame_cnt_o,
    output logic [7:0]                resync_cnt_o,
    output logic                      dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 2 * LANE_W;
    localparam int BW = DATA_WIDTH + 3;

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_credit;
    logic          w_space;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_accept;
    logic          w_sop;
    logic          w_eop;
    logic          w_err;
    logic          w_frame_inc;
    logic          w_resync_inc;
    logic          w_pop;

    logic [15:0]   r_frame_cnt;
    logic [7:0]    r_resync_cnt;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_l;
    logic [DATA_WIDTH-1:0] r_s1_s;
    logic [2:0]            r_s1_mark;
    logic                  r_s2_valid;
    logic [LANES-1:0][PW-1:0] r_s2_pa;
    logic [LANES-1:0][PW-1:0] r_s2_pb;
    logic [2:0]            r_s2_mark;
    logic                  r_s3_valid;
    logic [DATA_WIDTH-1:0] r_s3_data;
    logic [2:0]            r_s3_mark;

    logic [LANES-1:0][PW-1:0] w_pa;
    logic [LANES-1:0][PW-1:0] w_pb;
    logic [DATA_WIDTH-1:0]    w_res;

    logic [BW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_load;
    logic          r_out_valid;
    logic [BW-1:0] r_out_word;

    assign w_space = (r_credit < CW'(FIFO_DEPTH));
    assign w_pop   = r_out_valid & aso_src.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ALIGN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Marker word for the accepted pair is {error, eop, sop}.
    always_comb begin
        w_rdy0       = 1'b0;
        w_rdy1       = 1'b0;
        w_accept     = 1'b0;
        w_sop        = 1'b0;
        w_eop        = 1'b0;
        w_err        = 1'b0;
        w_frame_inc  = 1'b0;
        w_resync_inc = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            ST_ALIGN: begin
                if (asi_snk_0.valid && asi_snk_0.startofpacket &&
                    asi_snk_1.valid && asi_snk_1.startofpacket && w_space) begin
                    w_rdy0   = 1'b1;
                    w_rdy1   = 1'b1;
                    w_accept = 1'b1;
                    w_sop    = 1'b1;
                    w_eop    = asi_snk_0.endofpacket & asi_snk_1.endofpacket;
                    if (asi_snk_0.endofpacket && asi_snk_1.endofpacket) begin
                        w_frame_inc = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    // Non-SOP heads are discarded; SOP heads wait for their partner.
                    w_rdy0 = asi_snk_0.valid & ~asi_snk_0.startofpacket;
                    w_rdy1 = asi_snk_1.valid & ~asi_snk_1.startofpacket;
                end
            end
            ST_RUN: begin
                w_rdy0   = w_space & asi_snk_1.valid;
                w_rdy1   = w_space & asi_snk_0.valid;
                w_accept = w_space & asi_snk_0.valid & asi_snk_1.valid;
                if (w_accept) begin
                    if (asi_snk_0.startofpacket || asi_snk_1.startofpacket ||
                        (asi_snk_0.endofpacket ^ asi_snk_1.endofpacket)) begin
                        w_err        = 1'b1;
                        w_eop        = 1'b1;
                        w_resync_inc = 1'b1;
                        w_state_nxt  = ST_ALIGN;
                    end else if (asi_snk_0.endofpacket && asi_snk_1.endofpacket) begin
                        w_eop       = 1'b1;
                        w_frame_inc = 1'b1;
                        w_state_nxt = ST_ALIGN;
                    end
                end
            end
            default: w_state_nxt = ST_ALIGN;
        endcase
    end

    assign asi_snk_0.ready = w_rdy0 & ~rst;
    assign asi_snk_1.ready = w_rdy1 & ~rst;
    assign dbg_state_o     = (r_state == ST_RUN);
    assign frame_cnt_o     = r_frame_cnt;
    assign resync_cnt_o    = r_resync_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit     <= '0;
            r_frame_cnt  <= '0;
            r_resync_cnt <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_resync_inc && (r_resync_cnt != 8'hFF)) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end
        end
    end

    // out = (L*(2^W - L) + S*L) >> W; the sum never exceeds 2W bits.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PW-1:0] w_l;
        logic [PW-1:0] w_s;
        logic [PW-1:0] w_inv;
        assign w_l     = {{LANE_W{1'b0}}, r_s1_l[k*LANE_W +: LANE_W]};
        assign w_s     = {{LANE_W{1'b0}}, r_s1_s[k*LANE_W +: LANE_W]};
        assign w_inv   = PW'(1 << LANE_W) - w_l;
        assign w_pa[k] = w_l * w_inv;
        assign w_pb[k] = w_s * w_l;
        assign w_res[k*LANE_W +: LANE_W] = LANE_W'((r_s2_pa[k] + r_s2_pb[k]) >> LANE_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_l     <= '0;
            r_s1_s     <= '0;
            r_s1_mark  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_pa    <= '0;
            r_s2_pb    <= '0;
            r_s2_mark  <= '0;
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
            r_s3_mark  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_l    <= asi_snk_0.data;
                r_s1_s    <= asi_snk_1.data;
                r_s1_mark <= {w_err, w_eop, w_sop};
            end
            r_s2_valid <= r_s1_valid;
            r_s2_pa    <= w_pa;
            r_s2_pb    <= w_pb;
            r_s2_mark  <= r_s1_mark;
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= w_res;
            r_s3_mark  <= r_s2_mark;
        end
    end

    // Credits bound FIFO plus output register occupancy, so a write always finds room.
    assign w_load = (r_count != '0) && (!r_out_valid || aso_src.ready);

    always_ff @(posedge clk) begin
        if (r_s3_valid) begin
            r_mem[r_wr_ptr] <= {r_s3_mark, r_s3_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
        end else begin
            if (r_s3_valid) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({r_s3_valid, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_word  <= r_mem[r_rd_ptr];
            end else if (aso_src.ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign aso_src.valid = r_out_valid;
    assign {aso_src.error, aso_src.endofpacket, aso_src.startofpacket, aso_src.data} = r_out_word;
endmodule
